// File: rtl/lsu_dcache_arbiter.sv
// Shares the single dcache request port between LSU loads and committed-store drain,
// tracks in-flight loads against a credit limit, and sequences memory fences.
module lsu_dcache_arbiter #(
    parameter int XLEN            = 64,
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ld_req_valid,
    output logic            ld_req_ready,
    input  logic [XLEN-1:0] ld_req_addr,
    input  logic            st_req_valid,
    output logic            st_req_ready,
    input  logic [XLEN-1:0] st_req_addr,
    input  logic [XLEN-1:0] st_req_data,
    input  logic [7:0]      st_req_mask,
    input  logic            st_urgent,
    input  logic            sq_empty,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            ld_rsp_valid,
    output logic [XLEN-1:0] ld_rsp_data,
    input  logic            fence_req,
    output logic            fence_busy,
    output logic            fence_done
);

    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);
    localparam logic [OUT_W-1:0] OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [ST_W-1:0]  starve_cnt;
    logic [OUT_W-1:0] outstanding;

    logic ld_elig, st_elig, st_prio, ld_win, st_win, ld_acc, st_acc;

    // A load may issue at the credit limit if a response frees a slot this same cycle.
    assign ld_elig = ld_req_valid && (state == S_IDLE) &&
                     ((outstanding < OUT_MAX) || mem_rsp_valid);
    assign st_elig = st_req_valid;
    assign st_prio = st_urgent || (starve_cnt == STARVE_MAX);
    assign st_win  = st_elig && (st_prio || !ld_elig);
    assign ld_win  = ld_elig && !st_win;
    assign ld_acc  = ld_win && mem_req_ready;
    assign st_acc  = st_win && mem_req_ready;

    // Outputs are forced low while rstn is held so nothing leaks out before state is valid.
    assign mem_req_valid = rstn && (ld_elig || st_elig);
    assign ld_req_ready  = rstn && ld_acc;
    assign st_req_ready  = rstn && st_acc;
    assign mem_req_we    = st_win;
    assign mem_req_addr  = st_win ? st_req_addr : ld_req_addr;
    assign mem_req_wdata = st_win ? st_req_data : '0;
    assign mem_req_wmask = st_win ? st_req_mask : '0;

    assign ld_rsp_valid = rstn && mem_rsp_valid;
    assign ld_rsp_data  = mem_rsp_data;

    assign fence_busy = rstn && (state != S_IDLE);
    assign fence_done = rstn && (state == S_DONE);

    // DRAIN exit looks at the registered credit count, so DONE lands one cycle later.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fence_req) state_nxt = S_DRAIN;
            S_DRAIN: if (sq_empty && (outstanding == '0)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            outstanding <= '0;
        end else begin
            state <= state_nxt;

            if (st_acc || !st_req_valid)
                starve_cnt <= '0;
            else if (ld_acc && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + ST_W'(1);

            if (ld_acc && !mem_rsp_valid)
                outstanding <= outstanding + OUT_W'(1);
            else if (!ld_acc && mem_rsp_valid && (outstanding != '0))
                outstanding <= outstanding - OUT_W'(1);
        end
    end

    // A response with no load in flight is a protocol violation upstream.
    always_ff @(posedge clk) begin
        if (rstn)
            assert (!(mem_rsp_valid && (outstanding == '0)));
    end

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Directed table-driven bench for lsu_dcache_arbiter with hand-written fence and reset sequences.
module tb_lsu_dcache_arbiter;

    localparam int XLEN = 64;
    localparam logic [63:0] LD_ADDR = 64'h0000_0000_0000_1000;
    localparam logic [63:0] ST_ADDR = 64'h0000_0000_0000_2000;
    localparam logic [63:0] ST_DATA = 64'hDEAD_BEEF_0123_4567;
    localparam logic [7:0]  ST_MASK = 8'h0F;

    logic            clk = 1'b0;
    logic            rstn;
    logic            ld_req_valid, ld_req_ready;
    logic [XLEN-1:0] ld_req_addr;
    logic            st_req_valid, st_req_ready;
    logic [XLEN-1:0] st_req_addr, st_req_data;
    logic [7:0]      st_req_mask;
    logic            st_urgent, sq_empty;
    logic            mem_req_valid, mem_req_ready, mem_req_we;
    logic [XLEN-1:0] mem_req_addr, mem_req_wdata;
    logic [7:0]      mem_req_wmask;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            ld_rsp_valid;
    logic [XLEN-1:0] ld_rsp_data;
    logic            fence_req, fence_busy, fence_done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_dcache_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rstn(rstn),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_addr(st_req_addr),
        .st_req_data(st_req_data), .st_req_mask(st_req_mask),
        .st_urgent(st_urgent), .sq_empty(sq_empty),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .fence_req(fence_req), .fence_busy(fence_busy), .fence_done(fence_done)
    );

    typedef struct packed {
        logic ld, st, urg, mrdy, rsp;
        logic exp_mv, exp_we, exp_ldr, exp_str;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
    task automatic step(input logic ld, input logic st, input logic urg, input logic mrdy,
                        input logic rsp, input logic sqe, input logic frq);
        @(negedge clk);
        ld_req_valid  = ld;
        st_req_valid  = st;
        st_urgent     = urg;
        mem_req_ready = mrdy;
        mem_rsp_valid = rsp;
        mem_rsp_data  = mem_rsp_data + 64'h11;
        sq_empty      = sqe;
        fence_req     = frq;
        #1;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_mv"},   mem_req_valid, 0);
        check({tag, "_ldr"},  ld_req_ready, 0);
        check({tag, "_str"},  st_req_ready, 0);
        check({tag, "_busy"}, fence_busy, 0);
        check({tag, "_done"}, fence_done, 0);
        check({tag, "_rspv"}, ld_rsp_valid, 0);
    endtask

    initial begin
        logic prev_ld, exp_st;

        //            ld st ug rd rs | mv we ldr str
        vecs[0]  = '{1, 0, 0, 1, 0,   1, 0, 1, 0};  // out 0->1
        vecs[1]  = '{1, 0, 0, 1, 0,   1, 0, 1, 0};  // out 1->2
        vecs[2]  = '{1, 0, 0, 1, 0,   0, 0, 0, 0};  // credit limit
        vecs[3]  = '{1, 0, 0, 1, 0,   0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 1, 1,   1, 0, 1, 0};  // slot freed same cycle, out stays 2
        vecs[5]  = '{0, 0, 0, 1, 1,   0, 0, 0, 0};  // out 2->1
        vecs[6]  = '{0, 0, 0, 1, 1,   0, 0, 0, 0};  // out 1->0
        vecs[7]  = '{1, 1, 1, 1, 0,   1, 1, 0, 1};  // urgent store
        vecs[8]  = '{1, 1, 1, 1, 0,   1, 1, 0, 1};
        vecs[9]  = '{1, 1, 0, 1, 0,   1, 0, 1, 0};  // starve 1
        vecs[10] = '{1, 1, 0, 1, 1,   1, 0, 1, 0};  // starve 2
        vecs[11] = '{1, 1, 0, 1, 1,   1, 0, 1, 0};  // starve 3
        vecs[12] = '{1, 1, 0, 0, 1,   1, 0, 0, 0};  // stall, starve held at 3
        vecs[13] = '{1, 1, 0, 0, 0,   1, 0, 0, 0};
        vecs[14] = '{1, 1, 0, 0, 0,   1, 0, 0, 0};
        vecs[15] = '{1, 1, 0, 1, 0,   1, 0, 1, 0};  // starve 4
        vecs[16] = '{1, 1, 0, 1, 1,   1, 1, 0, 1};  // starved store wins
        vecs[17] = '{1, 1, 0, 1, 0,   1, 0, 1, 0};
        vecs[18] = '{0, 1, 0, 1, 1,   1, 1, 0, 1};  // store alone
        vecs[19] = '{0, 0, 0, 1, 0,   0, 0, 0, 0};

        rstn         = 1'b0;
        ld_req_addr  = LD_ADDR;
        st_req_addr  = ST_ADDR;
        st_req_data  = ST_DATA;
        st_req_mask  = ST_MASK;
        mem_rsp_data = 64'h0;
        step(1, 1, 0, 1, 1, 1, 1);
        check_all_low("rst_hold");
        @(posedge clk);
        step(0, 0, 0, 0, 0, 1, 0);
        rstn = 1'b1;
        #1;
        check_all_low("rst_rel");

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].st, vecs[i].urg, vecs[i].mrdy, vecs[i].rsp, 1'b1, 1'b0);
            check($sformatf("v%0d_mv", i),   mem_req_valid, vecs[i].exp_mv);
            check($sformatf("v%0d_ldr", i),  ld_req_ready,  vecs[i].exp_ldr);
            check($sformatf("v%0d_str", i),  st_req_ready,  vecs[i].exp_str);
            check($sformatf("v%0d_rspv", i), ld_rsp_valid,  vecs[i].rsp);
            if (vecs[i].rsp)
                check($sformatf("v%0d_rspd", i), ld_rsp_data, mem_rsp_data);
            if (vecs[i].exp_mv) begin
                check($sformatf("v%0d_we", i),    mem_req_we,    vecs[i].exp_we);
                check($sformatf("v%0d_addr", i),  mem_req_addr,  vecs[i].exp_we ? ST_ADDR : LD_ADDR);
                check($sformatf("v%0d_wdata", i), mem_req_wdata, vecs[i].exp_we ? ST_DATA : 64'h0);
                check($sformatf("v%0d_wmask", i), mem_req_wmask, vecs[i].exp_we ? 64'(ST_MASK) : 64'h0);
            end
        end

        // Continuous load+store traffic with immediate responses: four loads then one store.
        prev_ld = 1'b0;
        for (int c = 0; c < 15; c++) begin
            exp_st = (c % 5 == 4);
            step(1, 1, 0, 1, prev_ld, 1, 0);
            check($sformatf("p%0d_str", c), st_req_ready, exp_st);
            check($sformatf("p%0d_ldr", c), ld_req_ready, !exp_st);
            prev_ld = !exp_st;
        end

        // Fence with two loads in flight and three stores queued.
        step(1, 0, 0, 1, 0, 1, 0);
        check("f1_ldr", ld_req_ready, 1);
        step(1, 0, 0, 1, 0, 1, 1);
        check("f2_ldr", ld_req_ready, 1);
        check("f2_busy", fence_busy, 0);
        step(1, 1, 0, 1, 0, 0, 0);
        check("f3_busy", fence_busy, 1);
        check("f3_ldr", ld_req_ready, 0);
        check("f3_str", st_req_ready, 1);
        step(1, 1, 0, 1, 1, 0, 0);
        check("f4_ldr", ld_req_ready, 0);
        check("f4_str", st_req_ready, 1);
        step(1, 1, 0, 1, 1, 0, 0);
        check("f5_str", st_req_ready, 1);
        check("f5_done", fence_done, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        check("f6_ldr", ld_req_ready, 0);
        check("f6_done", fence_done, 0);
        check("f6_busy", fence_busy, 1);
        step(1, 0, 0, 1, 0, 1, 1);
        check("f7_done", fence_done, 1);
        check("f7_ldr", ld_req_ready, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        check("f8_done", fence_done, 0);
        check("f8_busy", fence_busy, 0);
        check("f8_ldr", ld_req_ready, 1);
        step(0, 0, 0, 1, 1, 1, 0);

        // Reset while draining with a load still in flight.
        step(1, 0, 0, 1, 0, 1, 0);
        check("r1_ldr", ld_req_ready, 1);
        step(0, 0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 1, 0, 1, 0);
        check("r3_busy", fence_busy, 1);
        step(1, 1, 0, 1, 1, 1, 0);
        rstn = 1'b0;
        #1;
        check_all_low("r4_hold");
        step(0, 0, 0, 1, 0, 1, 0);
        rstn = 1'b1;
        #1;
        check_all_low("r5_rel");
        step(1, 0, 0, 1, 0, 1, 0);
        check("r6_done", fence_done, 0);
        check("r6_ldr", ld_req_ready, 1);
        step(1, 0, 0, 1, 0, 1, 0);
        check("r7_ldr", ld_req_ready, 1);
        step(1, 0, 0, 1, 0, 1, 0);
        check("r8_ldr", ld_req_ready, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        check("r11_mv", mem_req_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_dcache_arbiter.md
# lsu_dcache_arbiter

Shares the single dcache request port between the LSU load path and the committed-store drain path. It arbitrates load and store requests and counts outstanding loads against a credit limit. It routes load responses back to the LSU and sequences memory fences: stores drain and in-flight loads complete before new loads are admitted. It sits between fu_lsu and the dcache port.

## Interface
- XLEN, 64, data/address width
- STARVE_LIMIT, 4, consecutive lost cycles after which a waiting store gets priority (>=1)
- MAX_OUTSTANDING, 2, max in-flight loads (>=1)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- ld_req_valid  in  1  load request valid
- ld_req_ready  out  1  load request accepted this cycle
- ld_req_addr  in  XLEN  load physical address
- st_req_valid  in  1  committed store at SQ head valid
- st_req_ready  out  1  store accepted (SQ pops on valid&&ready)
- st_req_addr  in  XLEN  store physical address
- st_req_data  in  XLEN  byte-lane-aligned store data
- st_req_mask  in  8  byte enable
- st_urgent  in  1  SQ almost full; store wins unconditionally
- sq_empty  in  1  store queue holds no valid entry
- mem_req_valid  out  1  dcache request valid
- mem_req_ready  in  1  dcache accepts request
- mem_req_we  out  1  1=store, 0=load
- mem_req_addr  out  XLEN  request address
- mem_req_wdata  out  XLEN  store data (0 for loads)
- mem_req_wmask  out  8  store mask (0 for loads)
- mem_rsp_valid  in  1  load data returns (in order)
- mem_rsp_data  in  XLEN  load data
- ld_rsp_valid  out  1  load response to LSU
- ld_rsp_data  out  XLEN  load data to LSU
- fence_req  in  1  start fence (single-cycle pulse)
- fence_busy  out  1  fence in progress
- fence_done  out  1  one-cycle pulse when the fence completes

## Operation
- Load eligible: ld_req_valid && state==IDLE && (outstanding<MAX_OUTSTANDING || mem_rsp_valid).
- Store eligible: st_req_valid (in every state).
- Priority: store if st_urgent or starve_cnt==STARVE_LIMIT; otherwise load; otherwise store.
- Winner drives mem_req_*; mem_req_valid = any eligible.
- Grant: the winner's ready = mem_req_ready. The loser's ready = 0.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - resets to 0 when a store is accepted or st_req_valid=0;
  - +1 on a cycle where st_req_valid, store not accepted, and a load is accepted;
  - saturates at STARVE_LIMIT.
- outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on load accept; -1 on mem_rsp_valid; unchanged if both occur;
  - mem_rsp_valid at outstanding==0 is a protocol error: assertion, counter held at 0.
- ld_rsp_valid = mem_rsp_valid and ld_rsp_data = mem_rsp_data, combinational passthrough. Store requests produce no response.
- FSM IDLE / DRAIN / DONE:
  - IDLE: on fence_req, go to DRAIN. A load accepted in that same cycle still counts as outstanding.
  - DRAIN: loads blocked, stores keep draining. Go to DONE when sq_empty && outstanding==0, evaluated on registered state after this cycle's updates.
  - DONE: fence_done=1; next cycle IDLE.
  - fence_busy = state!=IDLE.
  - fence_req while busy is ignored.
- Reset: state IDLE, starve_cnt 0, outstanding 0.
- All outputs are 0 during and after reset until inputs drive them: mem_req_valid, ld_req_ready, st_req_ready, fence_busy, fence_done, ld_rsp_valid.

## Timing
- Arbitration and grant are combinational: 0-cycle request-to-dcache path.
- Counters and FSM update on posedge clk.
- Handshake rules: valid must not depend on ready. Once asserted, a requester holds valid and payload until accepted.
- A winner that stalls because mem_req_ready=0 keeps priority: the starve counter is unchanged on cycles with no accept.
- The fence takes at least 2 cycles: DRAIN then DONE.
- fence_done fires exactly one cycle, on the cycle after the drain condition is first true.
- Reset mid-fence returns the FSM to IDLE with no fence_done.
- Reset clears outstanding; responses arriving after reset are dropped by the assertion rule.

## Test plan
- Loads only, MAX_OUTSTANDING=2, no responses: 2 loads accepted, 3rd held with ld_req_ready=0. Inject mem_rsp_valid: 3rd accepted in that same cycle and outstanding stays 2.
- Load and store valid continuously, STARVE_LIMIT=4, responses immediate: 4 loads granted, then 1 store, repeating with period 5.
- st_urgent=1 with load valid: store granted every cycle and load ready=0.
- mem_req_ready=0 for 3 cycles with a load winning: starve_cnt unchanged and load payload stable. On ready=1, the load is accepted.
- fence_req with 2 loads outstanding and 3 stores in SQ: loads blocked and stores drain. Once sq_empty and both responses are back, fence_done pulses one cycle later and loads resume.
- Assert rstn=0 during DRAIN: next cycle fence_busy=0, outstanding=0, no fence_done, all ready/valid outputs 0.
